anton_neopixel_apb_bridge: RTL

APB slave front end that drives the byte-wide pixel/register bus of the neopixel raw core: busAddr, busDataIn, busWrite, busRead and busDataOut. Each APB word access maps to one byte access. Word address PADDR[15:2] becomes busAddr[13:0]. Only PWDATA[7:0] and PRDATA[7:0] carry data. The bridge runs in the bus clock domain, inserts the wait states needed by the core's registered read data, and rejects accesses the core cannot decode.

---
 rtl/anton_neopixel_apb_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/anton_neopixel_apb_bridge.sv
// APB slave bridge onto the byte-wide neopixel core bus.
// One APB word access becomes one byte access. Out-of-range pixel accesses
// and writes to the read-only status register are answered with PSLVERR
// and never reach the core.
module anton_neopixel_apb_bridge #(
    parameter logic [12:0] BUFFER_END = 13'd1535
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   err_r;
    logic   err_nxt_s;
    logic   start_s;
    logic   pix_err_s;
    logic   reg_err_s;
    logic   dec_err_s;
    logic   null_wr_s;
    logic   unused_s;

    // Bits of the APB word that a byte-wide core has no use for.
    assign unused_s = ^{PADDR[1:0], PWDATA[31:8], PSTRB[3:1]};

    // Access decode: new access detection and error/null-write classification.
    always_comb begin
        start_s   = PSEL & PENABLE & ~PREADY;
        pix_err_s = ~PADDR[15] & (PADDR[14:2] > BUFFER_END);
        reg_err_s = PADDR[15] & PWRITE & (PADDR[3:2] == 2'd3);
        dec_err_s = pix_err_s | reg_err_s;
        null_wr_s = PWRITE & ~PSTRB[0];
    end

    // State register; reset abandons any transfer in progress.
    always_ff @(posedge busClk) begin
        if (busReset) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state logic and error flag tracking.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    err_nxt_s = dec_err_s;
                    if (dec_err_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (null_wr_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (PWRITE) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RD:   state_nxt_s = ST_CAP;
            ST_CAP:  state_nxt_s = ST_RESP;
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                err_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                err_nxt_s   = 1'b0;
            end
        endcase
    end

    // Registered outputs: strobes/handshake follow the next state, address
    // and data latch only when a new access is accepted in IDLE.
    always_ff @(posedge busClk) begin
        if (busReset) begin
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            busAddr   <= 14'd0;
            busDataIn <= 8'd0;
            PRDATA    <= 32'd0;
        end else begin
            busWrite <= (state_nxt_s == ST_WR);
            busRead  <= (state_nxt_s == ST_RD);
            PREADY   <= (state_nxt_s == ST_RESP);
            PSLVERR  <= (state_nxt_s == ST_RESP) & err_nxt_s;
            if ((state_r == ST_IDLE) && start_s) begin
                busAddr   <= PADDR[15:2];
                busDataIn <= PWDATA[7:0];
                if (dec_err_s && !PWRITE) begin
                    PRDATA <= 32'd0;
                end
            end
            if (state_r == ST_CAP) begin
                PRDATA <= {24'd0, busDataOut};
            end
        end
    end

endmodule
